multicycle_control: RTL and testbench

- Multi-cycle controller for the RV32I-subset datapath.
- Replaces single-cycle main decoding with an FSM that sequences fetch, decode, execute, memory and writeback over several cycles, sharing one ALU and one memory port.
- Handshakes with a variable-latency memory via mem_req/mem_ready.
- Flags illegal opcodes and memory timeouts by halting.

---
 rtl/multicycle_control_pkg.sv | 53 +++++
 rtl/multicycle_control_if.sv | 10 +
 rtl/multicycle_control_opcode_classify.sv | 26 ++
 rtl/multicycle_control.sv | 227 ++++++++++++++++++++++
 tb/tb_multicycle_control.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/multicycle_control_pkg.sv
// Shared constants and types for the multi-cycle RV32I-subset controller.
package ctrl_pkg;

    // Major opcodes recognised by the controller
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    // Controller sequencing states
    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        HALT   = 3'd5
    } state_e;

    // Instruction class latched in DECODE and used by later states
    typedef enum logic [2:0] {
        CLS_NONE   = 3'd0,
        CLS_R      = 3'd1,
        CLS_I      = 3'd2,
        CLS_LOAD   = 3'd3,
        CLS_STORE  = 3'd4,
        CLS_BRANCH = 3'd5,
        CLS_LUI    = 3'd6,
        CLS_AUIPC  = 3'd7
    } opc_class_e;

    // ALU operation classes
    localparam logic [3:0] ALU_ADD    = 4'b0000;
    localparam logic [3:0] ALU_IMM    = 4'b0010;
    localparam logic [3:0] ALU_STORE  = 4'b0100;
    localparam logic [3:0] ALU_R      = 4'b0110;
    localparam logic [3:0] ALU_BRANCH = 4'b1100;

    // ALU A-operand selects
    localparam logic [1:0] A_OLDPC = 2'b00;
    localparam logic [1:0] A_ZERO  = 2'b01;
    localparam logic [1:0] A_RS1   = 2'b10;
    localparam logic [1:0] A_PC    = 2'b11;

    // ALU B-operand selects
    localparam logic [1:0] B_RS2  = 2'b00;
    localparam logic [1:0] B_IMM  = 2'b01;
    localparam logic [1:0] B_FOUR = 2'b10;

endpackage

// File: rtl/multicycle_control_if.sv
// Memory handshake bundle between the controller and the shared memory port.
interface multicycle_control_if;
    logic mem_req;
    logic mem_we;
    logic mem_addr_sel;
    logic mem_ready;

    modport master (output mem_req, output mem_we, output mem_addr_sel, input mem_ready);
    modport slave  (input mem_req, input mem_we, input mem_addr_sel, output mem_ready);
endinterface

// File: rtl/multicycle_control_opcode_classify.sv
// Maps a 7-bit major opcode onto its instruction class and a legal flag.
module opcode_classify
    import ctrl_pkg::*;
(
    input  logic [6:0] opcode_i,
    output opc_class_e class_o,
    output logic       legal_o
);

    // Pure lookup; anything unrecognised is reported as illegal
    always_comb begin
        class_o = CLS_NONE;
        legal_o = 1'b1;
        case (opcode_i)
            OP_R:      class_o = CLS_R;
            OP_I:      class_o = CLS_I;
            OP_LOAD:   class_o = CLS_LOAD;
            OP_STORE:  class_o = CLS_STORE;
            OP_BRANCH: class_o = CLS_BRANCH;
            OP_LUI:    class_o = CLS_LUI;
            OP_AUIPC:  class_o = CLS_AUIPC;
            default:   legal_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle controller: sequences fetch/decode/execute/memory/writeback
// over a shared ALU and memory port, halting on illegal opcodes or timeouts.
module multicycle_control
    import ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_W          = 8
) (
    input  logic                 CLK,
    input  logic                 RESET_N,
    input  logic [6:0]           opcode,
    input  logic                 zero,
    multicycle_control_if.master mem,
    output logic                 ir_write,
    output logic                 pc_write,
    output logic                 pc_src,
    output logic [1:0]           AuipcLui,
    output logic [1:0]           ALUSrc,
    output logic [3:0]           ALUOp,
    output logic                 RegWrite,
    output logic                 MemtoReg,
    output logic                 instr_retired,
    output logic                 illegal,
    output logic                 bus_err
);

    localparam logic [CNT_W-1:0] LIMIT      = CNT_W'(TIMEOUT_CYCLES);
    localparam bit               TIMEOUT_EN = (TIMEOUT_CYCLES != 0);

    state_e           state_q, state_d;
    opc_class_e       opc_q, opc_d;
    logic             illegal_q, illegal_d;
    logic             bus_err_q, bus_err_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    opc_class_e       decClass;
    logic             decLegal;
    logic             waiting;
    logic             timeout;
    logic [CNT_W-1:0] cntInc;

    logic             memReq, memWe, memAddrSel;
    logic             irWrite, pcWrite, pcSrc;
    logic [1:0]       aSel, bSel;
    logic [3:0]       aluOp;
    logic             regWrite, memToReg, retired;

    opcode_classify u_classify (
        .opcode_i (opcode),
        .class_o  (decClass),
        .legal_o  (decLegal)
    );

    // A request is outstanding and unanswered only in FETCH or MEM
    always_comb begin
        waiting = ((state_q == FETCH) || (state_q == MEM)) && !mem.mem_ready;
        cntInc  = cnt_q + 1'b1;
        timeout = TIMEOUT_EN && waiting && (cntInc == LIMIT);
    end

    // Next-state sequencing, sticky error flags and the wait counter
    always_comb begin
        state_d   = state_q;
        opc_d     = opc_q;
        illegal_d = illegal_q;
        bus_err_d = bus_err_q;
        case (state_q)
            FETCH: begin
                if (mem.mem_ready) begin
                    state_d = DECODE;
                end else if (timeout) begin
                    state_d   = HALT;
                    bus_err_d = 1'b1;
                end
            end
            DECODE: begin
                opc_d = decClass;
                if (decLegal) begin
                    state_d = EXEC;
                end else begin
                    state_d   = HALT;
                    illegal_d = 1'b1;
                end
            end
            EXEC: begin
                case (opc_q)
                    CLS_R, CLS_I, CLS_LUI, CLS_AUIPC: state_d = WB;
                    CLS_LOAD, CLS_STORE:              state_d = MEM;
                    CLS_BRANCH:                       state_d = FETCH;
                    default:                          state_d = HALT;
                endcase
            end
            MEM: begin
                if (mem.mem_ready) begin
                    state_d = (opc_q == CLS_LOAD) ? WB : FETCH;
                end else if (timeout) begin
                    state_d   = HALT;
                    bus_err_d = 1'b1;
                end
            end
            WB:      state_d = FETCH;
            HALT:    state_d = HALT;
            default: state_d = HALT;
        endcase
        if (state_d != state_q) begin
            cnt_d = '0;
        end else if (waiting) begin
            cnt_d = cntInc;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            state_q   <= FETCH;
            opc_q     <= CLS_NONE;
            illegal_q <= 1'b0;
            bus_err_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            opc_q     <= opc_d;
            illegal_q <= illegal_d;
            bus_err_q <= bus_err_d;
            cnt_q     <= cnt_d;
        end
    end

    // Control strobes decoded from state and latched class; completion strobes are ready-qualified
    always_comb begin
        memReq     = 1'b0;
        memWe      = 1'b0;
        memAddrSel = 1'b0;
        irWrite    = 1'b0;
        pcWrite    = 1'b0;
        pcSrc      = 1'b0;
        aSel       = A_RS1;
        bSel       = B_RS2;
        aluOp      = ALU_ADD;
        regWrite   = 1'b0;
        memToReg   = 1'b0;
        retired    = 1'b0;
        case (state_q)
            FETCH: begin
                memReq = 1'b1;
                aSel   = A_PC;
                bSel   = B_FOUR;
                if (mem.mem_ready) begin
                    irWrite = 1'b1;
                    pcWrite = 1'b1;
                end
            end
            DECODE: begin
                aSel = A_OLDPC;
                bSel = B_IMM;
            end
            EXEC: begin
                case (opc_q)
                    CLS_R: begin
                        aluOp = ALU_R;
                    end
                    CLS_I: begin
                        aluOp = ALU_IMM;
                        bSel  = B_IMM;
                    end
                    CLS_LUI: begin
                        aluOp = ALU_IMM;
                        aSel  = A_ZERO;
                        bSel  = B_IMM;
                    end
                    CLS_AUIPC: begin
                        aluOp = ALU_IMM;
                        aSel  = A_OLDPC;
                        bSel  = B_IMM;
                    end
                    CLS_LOAD: begin
                        bSel = B_IMM;
                    end
                    CLS_STORE: begin
                        aluOp = ALU_STORE;
                        bSel  = B_IMM;
                    end
                    CLS_BRANCH: begin
                        aluOp   = ALU_BRANCH;
                        pcWrite = zero;
                        pcSrc   = 1'b1;
                        retired = 1'b1;
                    end
                    default: ;
                endcase
            end
            MEM: begin
                memReq     = 1'b1;
                memAddrSel = 1'b1;
                memWe      = (opc_q == CLS_STORE);
                retired    = mem.mem_ready && (opc_q == CLS_STORE);
            end
            WB: begin
                regWrite = 1'b1;
                memToReg = (opc_q == CLS_LOAD);
                retired  = 1'b1;
            end
            default: ;
        endcase
    end

    // Reset forces every output low, including the sticky flags
    always_comb begin
        mem.mem_req      = memReq     & RESET_N;
        mem.mem_we       = memWe      & RESET_N;
        mem.mem_addr_sel = memAddrSel & RESET_N;
        ir_write         = irWrite    & RESET_N;
        pc_write         = pcWrite    & RESET_N;
        pc_src           = pcSrc      & RESET_N;
        AuipcLui         = aSel  & {2{RESET_N}};
        ALUSrc           = bSel  & {2{RESET_N}};
        ALUOp            = aluOp & {4{RESET_N}};
        RegWrite         = regWrite  & RESET_N;
        MemtoReg         = memToReg  & RESET_N;
        instr_retired    = retired   & RESET_N;
        illegal          = illegal_q & RESET_N;
        bus_err          = bus_err_q & RESET_N;
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench: builds an expected per-cycle output trace for each
// instruction from the controller's published timing, then replays it.
module tb_multicycle_control;

    logic       CLK;
    logic       RESET_N;
    logic [6:0] opcode;
    logic       zero;
    logic       ir_write, pc_write, pc_src;
    logic [1:0] AuipcLui, ALUSrc;
    logic [3:0] ALUOp;
    logic       RegWrite, MemtoReg, instr_retired, illegal, bus_err;

    int nTests = 0;
    int nFail  = 0;

    multicycle_control_if bus ();

    multicycle_control #(.TIMEOUT_CYCLES(4), .CNT_W(8)) dut (
        .CLK           (CLK),
        .RESET_N       (RESET_N),
        .opcode        (opcode),
        .zero          (zero),
        .mem           (bus),
        .ir_write      (ir_write),
        .pc_write      (pc_write),
        .pc_src        (pc_src),
        .AuipcLui      (AuipcLui),
        .ALUSrc        (ALUSrc),
        .ALUOp         (ALUOp),
        .RegWrite      (RegWrite),
        .MemtoReg      (MemtoReg),
        .instr_retired (instr_retired),
        .illegal       (illegal),
        .bus_err       (bus_err)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic [18:0] exp;
        logic        rdy;
        logic [6:0]  opc;
        logic        z;
    } cyc_t;

    cyc_t trace[$];

    // Expected output vector in a fixed field order
    function automatic logic [18:0] ev(input logic req, input logic we, input logic asel,
                                       input logic irw, input logic pcw, input logic pcs,
                                       input logic [1:0] al, input logic [1:0] als,
                                       input logic [3:0] op, input logic rw, input logic m2r,
                                       input logic ret, input logic ill, input logic be);
        return {req, we, asel, irw, pcw, pcs, al, als, op, rw, m2r, ret, ill, be};
    endfunction

    function automatic logic [6:0] rnd7();
        logic [6:0] r;
        r = 7'($urandom);
        return r;
    endfunction

    function automatic logic rnd1();
        logic r;
        r = 1'($urandom);
        return r;
    endfunction

    task automatic push(input logic [18:0] e, input logic rdy, input logic [6:0] opc, input logic z);
        cyc_t c;
        c.exp = e;
        c.rdy = rdy;
        c.opc = opc;
        c.z   = z;
        trace.push_back(c);
    endtask

    // Reference model: one instruction as a list of cycles with fw fetch waits and mw memory waits
    task automatic push_instr(input logic [6:0] opc, input int fw, input int mw, input logic z);
        logic isLoad, isStore;
        isLoad  = (opc == 7'b0000011);
        isStore = (opc == 7'b0100011);
        for (int i = 0; i < fw; i++)
            push(ev(1,0,0, 0,0,0, 2'b11,2'b10,4'b0000, 0,0,0, 0,0), 1'b0, rnd7(), rnd1());
        push(ev(1,0,0, 1,1,0, 2'b11,2'b10,4'b0000, 0,0,0, 0,0), 1'b1, rnd7(), rnd1());
        push(ev(0,0,0, 0,0,0, 2'b00,2'b01,4'b0000, 0,0,0, 0,0), rnd1(), opc, rnd1());
        case (opc)
            7'b0110011: push(ev(0,0,0, 0,0,0, 2'b10,2'b00,4'b0110, 0,0,0, 0,0), rnd1(), rnd7(), rnd1());
            7'b0010011: push(ev(0,0,0, 0,0,0, 2'b10,2'b01,4'b0010, 0,0,0, 0,0), rnd1(), rnd7(), rnd1());
            7'b0110111: push(ev(0,0,0, 0,0,0, 2'b01,2'b01,4'b0010, 0,0,0, 0,0), rnd1(), rnd7(), rnd1());
            7'b0010111: push(ev(0,0,0, 0,0,0, 2'b00,2'b01,4'b0010, 0,0,0, 0,0), rnd1(), rnd7(), rnd1());
            7'b0000011: push(ev(0,0,0, 0,0,0, 2'b10,2'b01,4'b0000, 0,0,0, 0,0), rnd1(), rnd7(), rnd1());
            7'b0100011: push(ev(0,0,0, 0,0,0, 2'b10,2'b01,4'b0100, 0,0,0, 0,0), rnd1(), rnd7(), rnd1());
            default:    push(ev(0,0,0, 0,z,1, 2'b10,2'b00,4'b1100, 0,0,1, 0,0), rnd1(), rnd7(), z);
        endcase
        if (isLoad || isStore) begin
            for (int i = 0; i < mw; i++)
                push(ev(1,isStore,1, 0,0,0, 2'b10,2'b00,4'b0000, 0,0,0, 0,0), 1'b0, rnd7(), rnd1());
            push(ev(1,isStore,1, 0,0,0, 2'b10,2'b00,4'b0000, 0,0,isStore, 0,0), 1'b1, rnd7(), rnd1());
        end
        if (opc != 7'b1100011 && !isStore)
            push(ev(0,0,0, 0,0,0, 2'b10,2'b00,4'b0000, 1,isLoad,1, 0,0), rnd1(), rnd7(), rnd1());
    endtask

    task automatic push_halt(input int n, input logic ill, input logic be);
        for (int i = 0; i < n; i++)
            push(ev(0,0,0, 0,0,0, 2'b10,2'b00,4'b0000, 0,0,0, ill,be), rnd1(), rnd7(), rnd1());
    endtask

    // Replay the expected trace: drive inputs, settle, compare, advance one cycle
    task automatic run_trace(input string name);
        cyc_t        c;
        logic [18:0] act;
        int          idx;
        idx = 0;
        while (trace.size() > 0) begin
            c = trace.pop_front();
            bus.mem_ready = c.rdy;
            opcode        = c.opc;
            zero          = c.z;
            #1;
            act = {bus.mem_req, bus.mem_we, bus.mem_addr_sel, ir_write, pc_write, pc_src,
                   AuipcLui, ALUSrc, ALUOp, RegWrite, MemtoReg, instr_retired, illegal, bus_err};
            nTests++;
            if (act !== c.exp) begin
                nFail++;
                $display("[TB] FAIL %s cycle %0d: got %b expected %b", name, idx, act, c.exp);
            end
            idx++;
            @(negedge CLK);
        end
    endtask

    // One cycle of reset with memory claiming readiness; every output must be low
    task automatic test_reset(input string name);
        logic [18:0] act;
        RESET_N       = 1'b0;
        bus.mem_ready = 1'b1;
        opcode        = rnd7();
        zero          = 1'b1;
        #1;
        act = {bus.mem_req, bus.mem_we, bus.mem_addr_sel, ir_write, pc_write, pc_src,
               AuipcLui, ALUSrc, ALUOp, RegWrite, MemtoReg, instr_retired, illegal, bus_err};
        nTests++;
        if (act !== 19'd0) begin
            nFail++;
            $display("[TB] FAIL %s: outputs in reset got %b expected 0", name, act);
        end
        @(negedge CLK);
        RESET_N = 1'b1;
    endtask

    task automatic test_rtype();
        push_instr(7'b0110011, 0, 0, 1'b0);
        push_instr(7'b0110011, 0, 0, 1'b1);
        run_trace("rtype");
    endtask

    task automatic test_load_wait();
        push_instr(7'b0000011, 0, 3, 1'b0);
        run_trace("load_wait3");
    endtask

    task automatic test_branch();
        push_instr(7'b1100011, 0, 0, 1'b1);
        push_instr(7'b1100011, 0, 0, 1'b0);
        run_trace("branch");
    endtask

    task automatic test_illegal();
        push(ev(1,0,0, 1,1,0, 2'b11,2'b10,4'b0000, 0,0,0, 0,0), 1'b1, rnd7(), rnd1());
        push(ev(0,0,0, 0,0,0, 2'b00,2'b01,4'b0000, 0,0,0, 0,0), rnd1(), 7'b1111111, rnd1());
        push_halt(8, 1'b1, 1'b0);
        run_trace("illegal_halt");
        test_reset("illegal_reset");
        push_instr(7'b0010011, 0, 0, 1'b0);
        run_trace("illegal_restart");
    endtask

    task automatic test_timeout();
        for (int i = 0; i < 4; i++)
            push(ev(1,0,0, 0,0,0, 2'b11,2'b10,4'b0000, 0,0,0, 0,0), 1'b0, rnd7(), rnd1());
        push_halt(6, 1'b0, 1'b1);
        run_trace("timeout_fetch");
        test_reset("timeout_reset");
        push_instr(7'b0110111, 3, 0, 1'b0);
        push_instr(7'b0000011, 0, 3, 1'b0);
        run_trace("timeout_edge_ok");
        push_instr(7'b0100011, 0, 4, 1'b0);
        void'(trace.pop_back());
        push_halt(3, 1'b0, 1'b1);
        run_trace("timeout_mem");
        test_reset("timeout_mem_reset");
    endtask

    task automatic test_reset_mid_store();
        push_instr(7'b0100011, 0, 2, 1'b0);
        void'(trace.pop_back());
        run_trace("store_before_reset");
        test_reset("store_mid_reset");
        push_instr(7'b0010111, 0, 0, 1'b0);
        run_trace("store_after_reset");
    endtask

    // Random legal instruction stream with random wait states below the timeout
    task automatic test_random();
        logic [6:0] ops [7];
        ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011, 7'b0110111, 7'b0010111};
        for (int n = 0; n < 40; n++)
            push_instr(ops[$urandom_range(0, 6)], $urandom_range(0, 3), $urandom_range(0, 3), rnd1());
        run_trace("random");
    endtask

    initial begin
        RESET_N       = 1'b0;
        bus.mem_ready = 1'b0;
        opcode        = 7'd0;
        zero          = 1'b0;
        @(negedge CLK);
        test_reset("reset");
        test_rtype();
        test_load_wait();
        test_branch();
        test_illegal();
        test_timeout();
        test_reset_mid_store();
        test_random();
        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
